// File: rtl/lif_pkg.sv
// Shared definitions for the spiking-neuron blocks: decoder FSM states,
// default widths and a saturating-increment helper.
package lif_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dec_state_t;

  localparam int DEF_WINDOW_LOG2 = 8;
  localparam int DEF_OUT_W       = 8;
  localparam int DEF_ISI_W       = 8;

  // Increment val by one, sticking at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    logic [31:0] res;
    if (val >= max_val) begin
      res = max_val;
    end else begin
      res = val + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/spike_edge_det.sv
// Registered rising-edge detector for a spike train. The level is remembered
// every cycle so a spike held high for several cycles yields a single edge.
module spike_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic spike_in,
  output logic rise
);

  logic spike_prev_r;

  // Track the previous spike level regardless of decoder state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_prev_r <= 1'b0;
    end else begin
      spike_prev_r <= spike_in;
    end
  end

  assign rise = spike_in & ~spike_prev_r;

endmodule

// File: rtl/spike_rate_decoder.sv
// Turns a binary spike train into a spike count per fixed window (rate) and
// the most recent inter-spike interval (isi). All outputs are registered.
module spike_rate_decoder
  import lif_pkg::*;
#(
  parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int ISI_W       = DEF_ISI_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike_in,
  output logic [OUT_W-1:0] rate,
  output logic             rate_valid,
  output logic             rate_sat,
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid
);

  localparam logic [WINDOW_LOG2-1:0] WIN_LAST = '1;
  localparam logic [OUT_W-1:0]       OUT_MAX  = '1;
  localparam logic [ISI_W-1:0]       ISI_MAX  = '1;

  dec_state_t             state_r;
  logic [WINDOW_LOG2-1:0] win_cnt_r;
  logic [OUT_W-1:0]       spk_cnt_r;
  logic                   spk_ovf_r;
  logic [ISI_W-1:0]       isi_cnt_r;
  logic                   have_ref_r;

  logic                   rise_s;
  logic [OUT_W:0]         rate_sum_s;
  logic [OUT_W-1:0]       spk_next_s;
  logic [ISI_W-1:0]       isi_next_s;
  logic                   win_end_s;

  spike_edge_det u_edge (
    .clk      (clk),
    .rst      (rst),
    .spike_in (spike_in),
    .rise     (rise_s)
  );

  // Next-value helpers: window total including this cycle's edge, and the
  // saturated increments of the spike and interval counters.
  always_comb begin
    rate_sum_s = {1'b0, spk_cnt_r} + {{OUT_W{1'b0}}, rise_s};
    spk_next_s = OUT_W'(sat_inc(32'(spk_cnt_r), 32'(OUT_MAX)));
    isi_next_s = ISI_W'(sat_inc(32'(isi_cnt_r), 32'(ISI_MAX)));
    win_end_s  = (win_cnt_r == WIN_LAST);
  end

  // IDLE/RUN control plus the window and interval counters; leaving RUN
  // throws away the partial window and the interval reference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      win_cnt_r  <= '0;
      spk_cnt_r  <= '0;
      spk_ovf_r  <= 1'b0;
      isi_cnt_r  <= '0;
      have_ref_r <= 1'b0;
      rate       <= '0;
      rate_valid <= 1'b0;
      rate_sat   <= 1'b0;
      isi        <= '0;
      isi_valid  <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      isi_valid  <= 1'b0;
      case (state_r)
        IDLE: begin
          win_cnt_r  <= '0;
          spk_cnt_r  <= '0;
          spk_ovf_r  <= 1'b0;
          isi_cnt_r  <= '0;
          have_ref_r <= 1'b0;
          state_r    <= en ? RUN : IDLE;
        end
        RUN: begin
          if (!en) begin
            state_r    <= IDLE;
            win_cnt_r  <= '0;
            spk_cnt_r  <= '0;
            spk_ovf_r  <= 1'b0;
            isi_cnt_r  <= '0;
            have_ref_r <= 1'b0;
          end else begin
            // Window: an edge on the last cycle still belongs to this window.
            if (win_end_s) begin
              win_cnt_r  <= '0;
              spk_cnt_r  <= '0;
              spk_ovf_r  <= 1'b0;
              rate_valid <= 1'b1;
              rate_sat   <= spk_ovf_r | rate_sum_s[OUT_W];
              rate       <= (spk_ovf_r | rate_sum_s[OUT_W]) ? OUT_MAX
                                                            : rate_sum_s[OUT_W-1:0];
            end else begin
              win_cnt_r <= win_cnt_r + WINDOW_LOG2'(1'b1);
              if (rise_s) begin
                spk_cnt_r <= spk_next_s;
                spk_ovf_r <= spk_ovf_r | (spk_cnt_r == OUT_MAX);
              end
            end
            // Interval: the first edge after entering RUN only sets the reference.
            if (rise_s) begin
              isi_cnt_r  <= '0;
              have_ref_r <= 1'b1;
              if (have_ref_r) begin
                isi       <= isi_next_s;
                isi_valid <= 1'b1;
              end
            end else begin
              isi_cnt_r <= isi_next_s;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder with 16-cycle windows. A main
// instance (OUT_W=8) and a narrow instance (OUT_W=3) see the same stimulus.
// Expected rates come from hand-written tables; expected intervals come from
// edge timestamps taken while driving. Both are queued and popped on pulses.
module tb_spike_rate_decoder;

  localparam int WIN = 16;

  logic       clk = 1'b0;
  logic       rst, en, spike_in;
  logic [7:0] rate, isi, isi_s;
  logic       rate_valid, rate_sat, isi_valid;
  logic [2:0] rate_s;
  logic       rate_valid_s, rate_sat_s, isi_valid_s;

  spike_rate_decoder #(.WINDOW_LOG2(4), .OUT_W(8), .ISI_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .rate(rate), .rate_valid(rate_valid), .rate_sat(rate_sat),
    .isi(isi), .isi_valid(isi_valid)
  );

  spike_rate_decoder #(.WINDOW_LOG2(4), .OUT_W(3), .ISI_W(8)) dut_small (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .rate(rate_s), .rate_valid(rate_valid_s), .rate_sat(rate_sat_s),
    .isi(isi_s), .isi_valid(isi_valid_s)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] r; logic s; } rate_exp_t;
  typedef struct { logic [15:0] pat; int n; } win_vec_t;

  rate_exp_t  rate_q[$];
  rate_exp_t  small_q[$];
  logic [7:0] isi_q[$];
  rate_exp_t  mon_e;
  logic [7:0] mon_i;
  win_vec_t   vecs[9];

  int checks = 0, failures = 0;
  int now_c = 0, last_edge = 0, neg_n = 0, last_rv = -1, lat;
  bit run_b = 1'b0, have_ref_b = 1'b0, prev_s = 1'b0;
  logic [15:0] p;

  // Scoreboard: every valid pulse pops and compares one expected record.
  always @(negedge clk) begin
    neg_n = neg_n + 1;
    if (!rst) begin
      if (rate_valid) begin
        checks++;
        if (rate_q.size() == 0) begin
          failures++;
          $display("FAIL rate_extra: got rate=%0d sat=%0b, nothing expected", rate, rate_sat);
        end else begin
          mon_e = rate_q.pop_front();
          if (rate !== mon_e.r || rate_sat !== mon_e.s) begin
            failures++;
            $display("FAIL rate_value: got rate=%0d sat=%0b want rate=%0d sat=%0b",
                     rate, rate_sat, mon_e.r, mon_e.s);
          end
        end
        if (last_rv >= 0) begin
          checks++;
          if (neg_n - last_rv != WIN) begin
            failures++;
            $display("FAIL rate_period: got %0d cycles want %0d", neg_n - last_rv, WIN);
          end
        end
        last_rv = neg_n;
      end
      if (rate_valid_s) begin
        checks++;
        if (small_q.size() == 0) begin
          failures++;
          $display("FAIL small_extra: got rate=%0d sat=%0b, nothing expected", rate_s, rate_sat_s);
        end else begin
          mon_e = small_q.pop_front();
          if ({5'd0, rate_s} !== mon_e.r || rate_sat_s !== mon_e.s) begin
            failures++;
            $display("FAIL small_value: got rate=%0d sat=%0b want rate=%0d sat=%0b",
                     rate_s, rate_sat_s, mon_e.r, mon_e.s);
          end
        end
      end
      if (isi_valid) begin
        checks++;
        if (isi_q.size() == 0) begin
          failures++;
          $display("FAIL isi_extra: got isi=%0d, nothing expected", isi);
        end else begin
          mon_i = isi_q.pop_front();
          if (isi !== mon_i) begin
            failures++;
            $display("FAIL isi_value: got isi=%0d want %0d", isi, mon_i);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // One clock cycle with the given spike level; records interval expectations.
  task automatic cyc(input logic s);
    spike_in = s;
    if (run_b && s && !prev_s) begin
      if (have_ref_b) begin
        isi_q.push_back((now_c - last_edge > 255) ? 8'd255 : 8'(now_c - last_edge));
      end
      have_ref_b = 1'b1;
      last_edge  = now_c;
    end
    prev_s = s;
    @(posedge clk);
    #1;
    now_c++;
  endtask

  task automatic expect_rate(input int n);
    rate_q.push_back('{r: 8'(n), s: 1'b0});
    small_q.push_back('{r: (n > 7) ? 8'd7 : 8'(n), s: (n > 7)});
  endtask

  task automatic drop();
    en = 1'b0;
    run_b = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
  endtask

  // One IDLE cycle with en high; afterwards the first window is running.
  task automatic start_run();
    en = 1'b1;
    run_b = 1'b0;
    have_ref_b = 1'b0;
    cyc(1'b0);
    last_rv = -1;
    run_b = 1'b1;
  endtask

  task automatic drain(input string name);
    checks++;
    if (rate_q.size() != 0 || small_q.size() != 0 || isi_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: pending rate=%0d small=%0d isi=%0d want 0 0 0",
               name, rate_q.size(), small_q.size(), isi_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; spike_in = 1'b0;
    vecs[0] = '{16'h1FF8, 1};   // level held 10 cycles
    vecs[1] = '{16'h5555, 8};   // alternating train
    vecs[2] = '{16'h5555, 8};
    vecs[3] = '{16'h5555, 8};
    vecs[4] = '{16'h8000, 1};   // edge on last window cycle
    vecs[5] = '{16'h0000, 0};   // level carried in, no edge
    vecs[6] = '{16'h0001, 1};   // edge on first window cycle
    vecs[7] = '{16'hAAAA, 8};   // 8th edge on last cycle
    vecs[8] = '{16'h5555, 7};   // high level carried across the boundary

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    chk("por_rate", 32'(rate), 32'd0);
    chk("por_isi", 32'(isi), 32'd0);
    chk("por_rate_valid", 32'(rate_valid), 32'd0);
    chk("por_isi_valid", 32'(isi_valid), 32'd0);
    chk("por_rate_sat", 32'(rate_sat), 32'd0);
    rst = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    chk("idle_rate", 32'(rate), 32'd0);

    // Back-to-back windows from the table
    start_run();
    for (int k = 0; k < 9; k++) begin
      expect_rate(vecs[k].n);
      for (int i = 0; i < 16; i++) cyc(vecs[k].pat[i]);
    end
    cyc(1'b0);
    drain("table");

    // Reset asserted mid-window while spikes toggle
    cyc(1'b1); cyc(1'b0); cyc(1'b1); cyc(1'b0); cyc(1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_rate", 32'(rate), 32'd0);
    chk("rst_isi", 32'(isi), 32'd0);
    chk("rst_rate_valid", 32'(rate_valid), 32'd0);
    chk("rst_isi_valid", 32'(isi_valid), 32'd0);
    chk("rst_rate_sat", 32'(rate_sat), 32'd0);
    chk("rst_small_rate", 32'(rate_s), 32'd0);
    run_b = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) cyc(logic'(i % 2 == 0));
    chk("rst_hold_rate_valid", 32'(rate_valid), 32'd0);
    spike_in = 1'b0; prev_s = 1'b0; have_ref_b = 1'b0; last_rv = -1;
    rst = 1'b0;
    expect_rate(0);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc(1'b0);
      if (rate_valid) begin
        lat = k;
        break;
      end
    end
    chk("rst_first_window_latency", 32'(lat), 32'd17);

    // Enable dropped at window cycle 9 with 3 edges counted
    drop();
    start_run();
    expect_rate(5);
    p = 16'h0155;
    for (int i = 0; i < 16; i++) cyc(p[i]);
    p = 16'h0015;
    for (int i = 0; i < 9; i++) cyc(p[i]);
    en = 1'b0;
    run_b = 1'b0;
    for (int i = 0; i < 20; i++) cyc(logic'(i % 4 == 1));
    chk("drop_rate_hold", 32'(rate), 32'd5);
    chk("drop_isi_hold", 32'(isi), 32'd2);
    chk("drop_small_rate_hold", 32'(rate_s), 32'd5);
    start_run();
    expect_rate(2);
    p = 16'h0088;
    for (int i = 0; i < 16; i++) cyc(p[i]);
    cyc(1'b0);
    drain("enable_drop");

    // Interval saturation: two edges 300 cycles apart
    drop();
    start_run();
    expect_rate(1);
    repeat (17) expect_rate(0);
    expect_rate(1);
    cyc(1'b1);
    for (int i = 0; i < 299; i++) cyc(1'b0);
    cyc(1'b1);
    repeat (3) cyc(1'b0);
    cyc(1'b0);
    chk("isi_saturated", 32'(isi), 32'd255);
    drain("isi_sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
